// File: rtl/video_timing_gen.sv
// video_timing_gen: generic raster timing generator with a latency-compensated
// pixel request front end for ROM/RAM image sources, all in the pixel clock domain.
// Defining VTG_PATTERN_EN compiles in built-in test patterns selected by 'mode';
// without it, rgb always comes from pix_in and mode/sw_rgb are ignored.
//
// Pixel request interface: pix_req is a one-way strobe with no ready/back-pressure.
// In every cycle pix_req is high, the source must present the pixel addressed by
// (pix_x, pix_y) on pix_in exactly PIX_LAT cycles later; the timing outputs are
// delayed to meet it, so de/hsync/vsync/rgb appear PIX_LAT+1 cycles after pix_req.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int PIX_LAT    = 2,
  parameter int CW         = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [2:0]    sw_rgb,
  input  logic [23:0]   pix_in,
  output logic          pix_req,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [23:0]   rgb,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          active_c;
  logic          hs_c;
  logic          vs_c;

  // Raster position; held at the origin while disabled so a restart begins at (0,0)
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == CW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == CW'(V_TOTAL - 1)) ? '0 : v_cnt + CW'(1);
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  assign active_c = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
  assign hs_c     = (h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_END));
  assign vs_c     = (v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_END));

  // Stage 0 control: raw (polarity-free) sync/de/frame flags registered from the counters
  logic s0_hs;
  logic s0_vs;
  logic s0_fr;

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      pix_req <= 1'b0;
      s0_hs   <= 1'b0;
      s0_vs   <= 1'b0;
      s0_fr   <= 1'b0;
    end else begin
      pix_req <= active_c;
      s0_hs   <= hs_c;
      s0_vs   <= vs_c;
      s0_fr   <= active_c && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Request address: follows the raster while visible, otherwise keeps the last pixel asked for
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (enable && active_c) begin
      pix_x <= h_cnt;
      pix_y <= v_cnt;
    end
  end

`ifdef VTG_PATTERN_EN
  localparam int SW    = 29;
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_idx;
  logic [23:0] pat_c;
  logic        s0_sel;
  logic [23:0] s0_pat;

  // Bar index by threshold compares instead of a divider; columns past 8*BAR_W stay in bar 7
  always_comb begin
    bar_idx = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (h_cnt >= CW'(b * BAR_W)) bar_idx = 3'(b);
    end
  end

  // Pattern generator, evaluated at the same raster position as the request
  always_comb begin
    pat_c = 24'h0;
    case (mode)
      2'd1: pat_c = {{8{sw_rgb[2]}}, {8{sw_rgb[1]}}, {8{sw_rgb[0]}}};
      2'd2: begin
        case (bar_idx)
          3'd0:    pat_c = 24'hFFFFFF;
          3'd1:    pat_c = 24'hFFFF00;
          3'd2:    pat_c = 24'h00FFFF;
          3'd3:    pat_c = 24'h00FF00;
          3'd4:    pat_c = 24'hFF00FF;
          3'd5:    pat_c = 24'hFF0000;
          3'd6:    pat_c = 24'h0000FF;
          default: pat_c = 24'h000000;
        endcase
      end
      2'd3:    pat_c = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
      default: pat_c = 24'h0;
    endcase
  end

  // Stage 0 pixel source: external-vs-pattern select and pattern value ride the delay line
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      s0_sel <= 1'b0;
      s0_pat <= 24'h0;
    end else begin
      s0_sel <= (mode == 2'd0);
      s0_pat <= pat_c;
    end
  end
`else
  localparam int SW = 4;

  logic unused_cfg;
  assign unused_cfg = ^{mode, sw_rgb};
`endif

  // Bundle layout: {de, hs, vs, frame[, sel, pattern]}; all-zero is the idle state
  logic [SW-1:0] s0_bus;
  logic [SW-1:0] tail;
  logic [23:0]   src_pix;

`ifdef VTG_PATTERN_EN
  assign s0_bus  = {pix_req, s0_hs, s0_vs, s0_fr, s0_sel, s0_pat};
  assign src_pix = tail[24] ? pix_in : tail[23:0];
`else
  assign s0_bus  = {pix_req, s0_hs, s0_vs, s0_fr};
  assign src_pix = pix_in;
`endif

  if (PIX_LAT == 0) begin : g_no_dly
    assign tail = s0_bus;
  end else begin : g_dly
    logic [SW-1:0] dly_q [PIX_LAT];

    // Shift register matching the source read latency; keeps running while disabled so it drains
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < PIX_LAT; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= s0_bus;
        for (int i = 1; i < PIX_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign tail = dly_q[PIX_LAT-1];
  end

  // Output register: samples pix_in in the cycle the delayed de is high and applies sync polarity
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      de          <= 1'b0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      frame_start <= 1'b0;
      rgb         <= 24'h0;
    end else begin
      de          <= tail[SW-1];
      hsync       <= tail[SW-2] ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= tail[SW-3] ? V_SYNC_POL : ~V_SYNC_POL;
      frame_start <= tail[SW-4];
      rgb         <= tail[SW-1] ? src_pix : 24'h0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized raster bench with a scoreboard. A reference
// model computes each cycle's expected outputs from the raster position by plain
// arithmetic and queues them; a negedge monitor pops and compares against the DUT.
// Pattern expectations are included when VTG_PATTERN_EN is defined.
module tb_video_timing_gen;

  localparam int HA = 84, HFP = 4, HSW = 6, HBP = 5;
  localparam int VA = 40, VFP = 2, VSW = 2, VBP = 3;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam int LAT = 3;
  localparam int CW  = 12;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;
  localparam int W   = 28;  // {de, hsync, vsync, frame_start, rgb}

  localparam logic [W-1:0] IDLE = {1'b0, ~HPOL, ~VPOL, 1'b0, 24'h0};
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [1:0]    mode;
  logic [2:0]    sw_rgb;
  logic [23:0]   pix_in;
  logic          pix_req;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [23:0]   rgb;
  logic          frame_start;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .PIX_LAT(LAT), .CW(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .sw_rgb(sw_rgb),
    .pix_in(pix_in), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- external pixel source: LAT-cycle read latency ----------------
  logic [23:0] src_q [LAT];
  always @(posedge clk) begin
    src_q[0] <= {pix_x[7:0], pix_y[7:0], 8'h5A};
    for (int i = 1; i < LAT; i++) src_q[i] <= src_q[i-1];
  end
  assign pix_in = src_q[LAT-1];

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            errors = 0;
  int            checks = 0;
  bit            started = 0;
  int            k = 0;
  int            cur_h = 0;
  int            cur_v = 0;
  logic          exp_req = 1'b0;
  logic [CW-1:0] exp_px = '0;
  logic [CW-1:0] exp_py = '0;
  int            de_n = 0, fs_n = 0, hs_n = 0, vs_n = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Pixel value the spec calls for at (x,y) under the current source selection
  function automatic logic [23:0] exp_pixel(int x, int y);
    logic [23:0] p;
    int bw, b;
    p = {x[7:0], y[7:0], 8'h5A};
`ifdef VTG_PATTERN_EN
    case (mode)
      2'd1: p = {sw_rgb[2] ? 8'hFF : 8'h00, sw_rgb[1] ? 8'hFF : 8'h00, sw_rgb[0] ? 8'hFF : 8'h00};
      2'd2: begin
        bw = HA / 8;
        b  = (bw == 0) ? 7 : x / bw;
        if (b > 7) b = 7;
        p = BARS[b];
      end
      2'd3: p = (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
      default: p = {x[7:0], y[7:0], 8'h5A};
    endcase
`else
    bw = 0;
    b  = bw;
`endif
    return p;
  endfunction

  function automatic logic [W-1:0] exp_tuple(int x, int y);
    logic d, hs, vs, fs;
    d  = (x < HA) && (y < VA);
    hs = (x >= HA + HFP) && (x < HA + HFP + HSW);
    vs = (y >= VA + VFP) && (y < VA + VFP + VSW);
    fs = d && (x == 0) && (y == 0);
    return {d, hs ? HPOL : ~HPOL, vs ? VPOL : ~VPOL, fs, d ? exp_pixel(x, y) : 24'h0};
  endfunction

  // Reference model: one expected output per clock, LAT+1 cycles ahead of the DUT outputs
  always @(posedge clk) begin
    started = 1;
    if (!reset_n) begin
      exp_q.delete();
      for (int i = 0; i < LAT + 2; i++) exp_q.push_back(IDLE);
      k = 0;
      exp_req = 1'b0;
      exp_px = '0;
      exp_py = '0;
    end else if (!enable) begin
      exp_q.push_back(IDLE);
      k = 0;
      exp_req = 1'b0;
    end else begin
      exp_q.push_back(exp_tuple(k % HT, k / HT));
      exp_req = ((k % HT) < HA) && ((k / HT) < VA);
      if (exp_req) begin
        exp_px = CW'(k % HT);
        exp_py = CW'(k / HT);
      end
      k = (k + 1) % FT;
    end
    cur_h = k % HT;
    cur_v = k / HT;
  end

  // Monitor: compares every cycle's outputs and request address, keeps activity counts
  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_queue: no expected entry, got %h at %0t",
                 {de, hsync, vsync, frame_start, rgb}, $time);
      end else begin
        check("out", 32'({de, hsync, vsync, frame_start, rgb}), 32'(exp_q.pop_front()));
      end
      check("req", 32'({pix_req, pix_x, pix_y}), 32'({exp_req, exp_px, exp_py}));
      if (de) de_n++;
      if (frame_start) fs_n++;
      if (hsync == HPOL) hs_n++;
      if (vsync == VPOL) vs_n++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_random(int cycles, int change_odds);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, change_odds) == 0) begin
        mode   = 2'($urandom_range(0, 3));
        sw_rgb = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic wait_pos(int h, int v, string name);
    bit found;
    found = 0;
    for (int i = 0; i < FT + 10; i++) begin
      @(posedge clk); #2;
      if (cur_h == h && cur_v == v) begin
        found = 1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic wait_first_de(string name);
    int  cnt;
    bit  seen;
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (de) begin
        seen = 1;
        break;
      end
      cnt++;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(cnt), 32'(LAT + 2));
    check({name, "_first_px"}, 32'({frame_start, rgb}), 32'({1'b1, 24'h00005A}));
    @(posedge clk); #2;
  endtask

  // ---------------- stimulus ----------------
  int de0, fs0, hs0, vs0;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    mode    = 2'd0;
    sw_rgb  = 3'd0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    check("idle_after_reset", 32'({de, hsync, vsync, frame_start, rgb}), 32'(IDLE));

    // Two uninterrupted frames with random source changes, then activity totals
    de0 = de_n; fs0 = fs_n; hs0 = hs_n; vs0 = vs_n;
    enable = 1'b1;
    run_random(2 * FT + LAT + 2, 63);
    check("de_count", 32'(de_n - de0), 32'(2 * HA * VA));
    check("frame_start_count", 32'(fs_n - fs0), 32'd2);
    check("hsync_count", 32'(hs_n - hs0), 32'(2 * VT * HSW));
    check("vsync_count", 32'(vs_n - vs0), 32'(2 * VSW * HT));

    // One-cycle reset in the middle of a frame
    mode = 2'd0;
    wait_pos(50, 20, "wait_reset_point");
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    check("reset_idle", 32'({de, hsync, vsync, frame_start, rgb}), 32'(IDLE));
    check("reset_req", 32'({pix_req, pix_x, pix_y}), 32'd0);
    wait_first_de("reset_release");

    // Each source selection held for half a frame
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      for (int i = 0; i < FT / 2; i++) begin
        @(posedge clk); #2;
        if ($urandom_range(0, 99) == 0) sw_rgb = 3'($urandom_range(0, 7));
      end
    end

    // Enable dropped mid-line for 50 cycles
    mode = 2'd0;
    wait_pos(30, 10, "wait_disable_point");
    enable = 1'b0;
    repeat (LAT + 1) begin @(posedge clk); #2; end
    check("drain_hold", 32'(de), 32'd1);
    @(posedge clk); #2;
    check("drain_idle", 32'({de, hsync, vsync, frame_start, rgb}), 32'(IDLE));
    repeat (50 - (LAT + 2)) begin @(posedge clk); #2; end
    enable = 1'b1;
    wait_first_de("reenable");

    // One more frame of random traffic, then let the pipeline go idle
    run_random(FT, 31);
    enable = 1'b0;
    repeat (LAT + 3) begin @(posedge clk); #2; end
    check("final_idle", 32'({de, hsync, vsync, frame_start, rgb}), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator plus pixel-source front end for the HDMI transmitter path.
- Replaces fixed 640x480 counters with generic H/V timing, programmable sync polarity, and a latency-compensated pixel request interface for ROM/RAM image sources.
- Optional built-in test patterns.
- Runs entirely in the pixel clock domain; outputs drive the HDMI encoder's Data/Hsync/Vsync/DE inputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of hsync
- V_SYNC_POL, 0, asserted level of vsync
- PIX_LAT, 2, read latency of the external pixel source in clocks, range 0..7
- CW, 12, width of x/y coordinates

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  reset; synchronous, active-low
- enable  in  1  run raster; low holds counters at origin
- mode  in  2  pixel source select (see Optional Feature)
- sw_rgb  in  3  solid-colour enables R,G,B
- pix_in  in  24  pixel from external source, {R,G,B}
- pix_req  out  1  request pixel at pix_x/pix_y
- pix_x  out  CW  requested column
- pix_y  out  CW  requested row
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable
- rgb  out  24  output pixel {R,G,B}
- frame_start  out  1  one-cycle pulse with the first active pixel of each frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line phase order: active, FP, sync, BP.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h wrap and wraps 0 after V_TOTAL-1.
- Stage 0 (registered from counters):
  - pix_req = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE); pix_x=h_cnt, pix_y=v_cnt when pix_req, else hold last value.
  - Raw hs active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Raw vs active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Delay line: de, hs, vs and frame flag pass through PIX_LAT register stages.
  - pix_in is sampled in the cycle the delayed de is high.
  - de/hsync/vsync/rgb are valid exactly PIX_LAT+1 cycles after the matching pix_req cycle.
- rgb = selected pixel when de=1, else 24'h0.
- hsync = H_SYNC_POL when hs is active, else the inverse; vsync likewise with V_SYNC_POL.
- frame_start = 1 in the cycle de is high for x=0,y=0.
- Reset (reset_n=0 at posedge):
  - h_cnt, v_cnt, pix_x, pix_y = 0; pix_req, de, frame_start = 0; rgb = 0.
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL.
  - All delay stages cleared to the idle state.
  - Reset mid-frame aborts immediately; the first de after release is pixel (0,0).
- enable=0: counters are forced to 0 and stage 0 emits idle. The delay line drains, so outputs go idle after PIX_LAT+1 cycles. On enable rising, raster restarts at (0,0).
- mode and sw_rgb changes take effect at the next pixel; no frame alignment.

Optional Feature:
- Macro VTG_PATTERN_EN.
- When defined, mode selects the pixel source. Pattern values are delayed through the same PIX_LAT pipeline.
  - 0: pix_in.
  - 1: solid colour; each channel is 8'hFF if its sw_rgb bit is set, else 8'h00.
  - 2: eight vertical bars, each H_ACTIVE/8 wide (integer); remainder columns use bar 7. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - 3: checkerboard; white if pix_x[5]^pix_y[5], else black.
- When undefined, mode and sw_rgb are ignored and rgb is always pix_in. No pattern logic is synthesised.

Test Plan:
- Defaults, reset then enable=1 for 2 frames:
  - hsync low for 96 clocks every 800; vsync low for 2 lines every 525.
  - de high 640 clocks per line on 480 lines; frame_start once per 420000 clocks.
- PIX_LAT=3, pix_in = {pix_x[7:0], pix_y[7:0], 8'h5A} modelled with 3-cycle latency: every de cycle rgb equals the expected coordinates; first de is exactly 4 clocks after the first pix_req.
- H_SYNC_POL=1, V_SYNC_POL=1, small timing (H 8/2/3/2, V 4/1/1/1):
  - hsync high 3 of 15 clocks; vsync high 15 of 105 clocks.
  - Counter wrap and line boundaries are correct.
- Assert reset_n=0 for 1 cycle at pixel (300,200): next cycle all outputs are idle; after release the first de carries x=0,y=0 with frame_start=1.
- enable low mid-line for 50 cycles: de=0 within PIX_LAT+1 cycles; after re-enable the raster restarts from (0,0).
- With VTG_PATTERN_EN:
  - mode=2: rgb=FFFFFF at x=0, FFFF00 at x=80, 000000 at x=639.
  - mode=1, sw_rgb=3'b101: rgb=FF00FF.
  - mode=3: x=32,y=0 is white; x=32,y=32 is black.
